// File: rtl/seq_detect_pkg.sv
// Shared constants, types and helpers for the programmable serial sequence detector.
package seq_detect_pkg;

    localparam logic [7:0] DEFAULT_PATTERN = 8'b0000_1001;
    localparam int         DEFAULT_LEN     = 4;
    localparam bit         DEFAULT_OVERLAP = 1'b1;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

    // Width needed to hold a length value in the range 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && !(&count_reg)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
    assign sat   = &count_reg;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: compares the newest L received bits against a
// loaded pattern, with overlapping or non-overlapping detection and a match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = DEFAULT_PATTERN,
    parameter int                 DEF_LEN     = DEFAULT_LEN,
    parameter bit                 DEF_OVERLAP = DEFAULT_OVERLAP,
    localparam int                LW          = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    localparam int DEF_LEN_EFF = (DEF_LEN > MAX_LEN) ? MAX_LEN : DEF_LEN;

    logic [MAX_LEN-1:0] history_reg, history_next, shifted;
    logic [MAX_LEN-1:0] pattern_reg, len_mask;
    logic [LW-1:0]      fill_reg, fill_next, len_reg, cfg_len_eff;
    logic [LW:0]        fill_inc;
    mode_e              mode_reg;
    logic               match_reg;
    logic               hit;

    assign cfg_len_eff = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;

    // Only the low L bits take part in the compare.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (LW'(gi) < len_reg);
        end
    endgenerate

    always_comb begin
        shifted      = {history_reg[MAX_LEN-2:0], in_bit};
        fill_inc     = {1'b0, fill_reg} + (LW+1)'(1);
        history_next = history_reg;
        fill_next    = fill_reg;
        hit          = in_valid && !cfg_load && (len_reg != '0)
                       && (fill_inc >= {1'b0, len_reg})
                       && (((shifted ^ pattern_reg) & len_mask) == '0);
        if (in_valid) begin
            history_next = shifted;
            // Non-overlap: a new match must be built entirely from fresh bits.
            if (hit && mode_reg == MODE_NONOVL) begin
                fill_next = '0;
            end else if (fill_reg != LW'(MAX_LEN)) begin
                fill_next = fill_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history_reg <= '0;
            fill_reg    <= '0;
            pattern_reg <= DEF_PATTERN;
            len_reg     <= LW'(DEF_LEN_EFF);
            mode_reg    <= mode_e'(DEF_OVERLAP);
            match_reg   <= 1'b0;
        end else if (cfg_load) begin
            history_reg <= '0;
            fill_reg    <= '0;
            pattern_reg <= cfg_pattern;
            len_reg     <= cfg_len_eff;
            mode_reg    <= mode_e'(cfg_overlap);
            match_reg   <= 1'b0;
        end else begin
            history_reg <= history_next;
            fill_reg    <= fill_next;
            match_reg   <= hit;
        end
    end

    assign match = match_reg;

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (hit),
        .count (match_cnt),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed scoreboard bench for seq_detect_prog; a narrow counter makes saturation reachable.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LW      = 4;
    localparam int CNT_MAX = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;

    typedef struct {
        string name;
        bit    m;
        int    c;      // -1: counter not checked on this transaction
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;

    seq_detect_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_cnt   (match_cnt),
        .cnt_sat     (cnt_sat)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Monitor: one expected response per clock edge issued by the driver.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            $display("txn %0d %s match=%0b cnt=%0d sat=%0b", txn, e.name, match, match_cnt, cnt_sat);
            check_val({e.name, " match"}, 32'(match), 32'(e.m));
            if (e.c >= 0) begin
                check_val({e.name, " cnt"}, 32'(match_cnt), 32'(e.c));
                check_val({e.name, " sat"}, 32'(cnt_sat), 32'(e.c == CNT_MAX));
            end
        end
    end

    task automatic tx(input string name, input bit v, input bit b, input bit ld,
                      input bit clr, input bit em, input int ec);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        cfg_load = ld;
        cnt_clr  = clr;
        e.name = name;
        e.m    = em;
        e.c    = ec;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Bits are sent MSB first; em holds the expected match after each bit, same order.
    task automatic send(input string name, input logic [15:0] bits, input int n,
                        input logic [15:0] em, input int cnt_end);
        for (int i = n - 1; i >= 0; i--) begin
            tx(name, 1'b1, bits[i], 1'b0, 1'b0, em[i], (i == 0) ? cnt_end : -1);
        end
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl, input int ec);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        tx("load", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ec);
    endtask

    task automatic clear();
        tx("clr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic idle(input string name);
        tx(name, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("reset match", 32'(match), 32'd0);
        check_val("reset cnt", 32'(match_cnt), 32'd0);
        check_val("reset sat", 32'(cnt_sat), 32'd0);

        // Default configuration, overlapping.
        send("ovl", 16'b1001001, 7, 16'b0001001, 2);

        // Non-overlapping; load leaves the counter alone.
        load(8'b0000_1001, 4'd4, 1'b0, 2);
        clear();
        send("novl_a", 16'b1001, 4, 16'b0001, 1);
        send("novl_b", 16'b001, 3, 16'b000, 1);
        send("novl_c", 16'b1001, 4, 16'b0001, 2);

        // Length 3 with junk above bit 2, gaps between bits.
        clear();
        load(8'b1010_1110, 4'd3, 1'b1, 0);
        tx("gap_b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        repeat (3) idle("gap");
        tx("gap_b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        repeat (3) idle("gap");
        tx("gap_b3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        // Load discards partial history and the coincident bit.
        clear();
        load(8'b0000_1001, 4'd4, 1'b1, 0);
        send("pre_ld", 16'b100, 3, 16'b000, 0);
        cfg_pattern = 8'b0000_1001; cfg_len = 4'd4; cfg_overlap = 1'b1;
        tx("load_drop", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        send("post_ld1", 16'b1, 1, 16'b0, 0);
        send("post_ld", 16'b001, 3, 16'b001, 1);

        // Oversized length clamps to MAX_LEN.
        clear();
        load(8'b1011_0011, 4'd15, 1'b1, 0);
        send("clamp", 16'b1011_0011, 8, 16'b0000_0001, 1);

        // Zero length disables detection.
        load(8'b0000_0000, 4'd0, 1'b1, 1);
        send("len0", 16'b0000, 4, 16'b0000, 1);

        // Saturation, then clear coincident with a hit.
        clear();
        load(8'b0000_0001, 4'd1, 1'b1, 0);
        send("sat1", 16'b1, 1, 16'b1, 1);
        send("sat2", 16'b1, 1, 16'b1, 2);
        send("sat3", 16'b1, 1, 16'b1, 3);
        send("sat4", 16'b1, 1, 16'b1, 3);
        tx("sat5_clr", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);

        // Asynchronous reset mid-pattern restores defaults.
        load(8'b0000_1001, 4'd4, 1'b1, 0);
        send("rst_pre", 16'b1001100, 7, 16'b0001000, 1);
        #3;
        rst = 1'b1;
        #1;
        check_val("async rst match", 32'(match), 32'd0);
        check_val("async rst cnt", 32'(match_cnt), 32'd0);
        check_val("async rst sat", 32'(cnt_sat), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        send("rst_post1", 16'b1, 1, 16'b0, 0);
        send("rst_post", 16'b1001, 4, 16'b0001, 1);

        idle("drain");
        repeat (3) @(posedge clk);
        #2;
        check_val("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
